aes_key_expander: RTL and testbench
===================================

# aes_key_expander

AES-128 key schedule engine sitting directly upstream of the AES encryptor. It accepts a 128-bit cipher key, iteratively computes round keys 1..10 (one per clock), and stores all eleven round keys in an internal register file. The encryptor then reads the key for the current round by driving its round-select index. Keys use the encryptor's state-matrix byte layout, so the encryptor consumes them without reordering.

## Interface
- No parameters. AES-128 only; 11 round keys.
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous, active-low reset.
- CipherKey  input  128  cipher key in matrix layout. Bits [127:96] = row 0 (col0..col3 MSB→LSB); [95:64] = row 1; [63:32] = row 2; [31:0] = row 3. FIPS word w_j = {row0[j], row1[j], row2[j], row3[j]}.
- Load  input  1  single-cycle request to capture CipherKey and expand it.
- SelKey  input  4  round-key index from the encryptor.
- Key  output  128  round key selected by SelKey, in the same matrix layout.
- Busy  output  1  high while expansion is in progress.
- KeyRy  output  1  high when all 11 round keys are valid.

## Operation
- States:
  - IDLE: Busy=0, KeyRy=0.
  - EXPAND: Busy=1, round counter rc runs 1..10.
  - DONE: KeyRy=1.
- Load sampled high in IDLE or DONE:
  - Write CipherKey into entry 0.
  - Set rc=1, clear KeyRy, and go to EXPAND.
- Load is ignored while in EXPAND.
- Each EXPAND cycle computes entry rc from entry rc−1:
  - t = SubWord(RotWord(w3)) ^ {Rcon[rc], 24'h0}
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'
  - RotWord(a,b,c,d) = (b,c,d,a).
  - SubWord uses 4 combinational S-box instances (FIPS-197 table).
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36, taken from a case on rc (no multiplier).
- After writing entry 10, go to DONE. Stay in DONE until the next Load or reset.
- Key read path is combinational from the register file:
  - SelKey 0..10 returns entry SelKey.
  - SelKey 11..15 returns entry 0.
- Key is valid for all indices only while KeyRy=1. Reading while Busy returns partially written contents; the consumer must wait for KeyRy.
- Reset (any time, including mid-expansion):
  - State→IDLE, rc=0, all 11 entries=0.
  - Busy=0, KeyRy=0, so Key=0 for every SelKey.

## Timing
- Load high at rising edge E0: entry 0 written at E0, Busy=1 after E0.
- Entry n written at edge E0+n, for n=1..10.
- At E0+10: Busy→0, KeyRy→1. Total latency is 10 cycles from the Load edge to KeyRy.
- Load held high for several cycles: only the first sample acts. Later samples during EXPAND are ignored. A sample still high when DONE is reached restarts expansion. Requesters must pulse Load for one cycle.
- Load in DONE: KeyRy falls at that same edge and the 10-cycle sequence restarts.
- Key changes in the same cycle SelKey changes (zero-cycle read latency), matching the encryptor's per-round key fetch.
- Rst deassertion is synchronised externally. The block assumes Rst releases away from a Clk edge.

## Test plan
- FIPS-197 key: Load 1 cycle with CipherKey=128'h2b28ab097eaef7cf15d2154f16a6883c -> KeyRy exactly 10 cycles later. Then:
  - SelKey=1 → Key=128'ha088232afa54a36cfe2c397617b13905
  - SelKey=2 → 128'hf27a5973c296355995b980f6f2437a7f
  - SelKey=10 → 128'hd0c9e1b614ee3f63f9250c0ca889c8a6
  - SelKey=0 and SelKey=13 → CipherKey.
- Zero key: Load CipherKey=0 -> SelKey=1 gives 128'h62626262636363636363636363636363; SelKey=10 gives 128'hb43e236fef92e98f5be25118cb11cf8e.
- Reset mid-expansion: Rst low 4 cycles after Load -> Busy=0, KeyRy=0, Key=0 for SelKey=0..15; a fresh Load then gives the correct FIPS keys.
- Load during EXPAND: second Load with a different key at cycle 5 -> ignored; keys equal those of the first key; KeyRy still at cycle 10.
- Reload from DONE: after the FIPS expansion completes, Load the zero key -> KeyRy drops at the Load edge and rises 10 cycles later; SelKey=1 gives 128'h62626262636363636363636363636363.
- Integration: connect to AES_Encryptor (SelKey/Key) with PT=128'h328831e0435a3137f6309807a88da234; assert En only after KeyRy -> CT=128'h3902dc1925dc116a8409850b1dfb9732.

Source files
------------

// File: rtl/aes_key_expander.sv
// AES-128 key schedule: expands a cipher key into 11 round keys, one per clock.
// Ports: Clk, Rst (async, active-low), CipherKey, Load, SelKey -> Key, Busy, KeyRy.

module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   always_comb begin
      y = SBOX[(255 - int'(a)) * 8 +: 8];
   end
endmodule

module aes_key_expander (
   input  logic         Clk,
   input  logic         Rst,
   input  logic [127:0] CipherKey,
   input  logic         Load,
   input  logic [3:0]   SelKey,
   output logic [127:0] Key,
   output logic         Busy,
   output logic         KeyRy
);
   typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

   state_t        state, state_nx;
   logic [3:0]    rc;
   logic [127:0]  rk [0:10];
   logic [127:0]  prev, next_key;
   logic [3:0][31:0] w, nw;
   logic [31:0]   rot, sub, t;
   logic [7:0]    rcon;

   // Source entry for the round being computed; guarded so a stray rc
   // never indexes past the register file.
   always_comb begin
      prev = rk[0];
      if (rc >= 4'd1 && rc <= 4'd10) prev = rk[rc - 4'd1];
   end

   // Matrix layout -> FIPS words: column c of each row forms word c.
   always_comb begin
      for (int c = 0; c < 4; c++) begin
         w[c] = {prev[127 - 8*c -: 8], prev[95 - 8*c -: 8],
                 prev[63 - 8*c -: 8],  prev[31 - 8*c -: 8]};
      end
   end

   assign rot = {w[3][23:0], w[3][31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_sbox
      aes_sbox u_sbox (
         .a(rot[8*i +: 8]),
         .y(sub[8*i +: 8])
      );
   end

   always_comb begin
      rcon = 8'h00;
      case (rc)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   end

   assign t = sub ^ {rcon, 24'h0};

   always_comb begin
      nw[0] = w[0] ^ t;
      nw[1] = w[1] ^ nw[0];
      nw[2] = w[2] ^ nw[1];
      nw[3] = w[3] ^ nw[2];
   end

   // FIPS words -> matrix layout.
   always_comb begin
      next_key = '0;
      for (int c = 0; c < 4; c++) begin
         next_key[127 - 8*c -: 8] = nw[c][31:24];
         next_key[95 - 8*c -: 8]  = nw[c][23:16];
         next_key[63 - 8*c -: 8]  = nw[c][15:8];
         next_key[31 - 8*c -: 8]  = nw[c][7:0];
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      Busy     = 1'b0;
      KeyRy    = 1'b0;
      case (state)
         IDLE: begin
            if (Load) state_nx = EXPAND;
         end
         EXPAND: begin
            Busy = 1'b1;
            if (rc == 4'd10) state_nx = DONE;
         end
         DONE: begin
            KeyRy = 1'b1;
            if (Load) state_nx = EXPAND;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         rc <= 4'd0;
         for (int i = 0; i <= 10; i++) rk[i] <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (Load) begin
                  rk[0] <= CipherKey;
                  rc    <= 4'd1;
               end
            end
            EXPAND: begin
               if (rc >= 4'd1 && rc <= 4'd10) rk[rc] <= next_key;
               if (rc != 4'd10) rc <= rc + 4'd1;
            end
            default: rc <= 4'd0;
         endcase
      end
   end

   // Indices past the last round alias to the cipher key.
   always_comb begin
      Key = rk[0];
      if (SelKey <= 4'd10) Key = rk[SelKey];
   end
endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander using FIPS-197 and zero-key vectors.
// Expected round keys are queued at Load and compared once KeyRy rises.

module tb_aes_key_expander;
   logic         clk;
   logic         rst;
   logic [127:0] cipher;
   logic         load;
   logic [3:0]   sel;
   logic [127:0] key;
   logic         busy;
   logic         ready;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [3:0]   sel;
      logic [127:0] key;
   } exp_t;

   exp_t sb[$];

   localparam logic [127:0] FIPS_K  = 128'h2b28ab097eaef7cf15d2154f16a6883c;
   localparam logic [127:0] FIPS_R1 = 128'ha088232afa54a36cfe2c397617b13905;
   localparam logic [127:0] FIPS_R2 = 128'hf27a5973c296355995b980f6f2437a7f;
   localparam logic [127:0] FIPS_RA = 128'hd0c9e1b614ee3f63f9250c0ca889c8a6;
   localparam logic [127:0] ZERO_R1 = 128'h62626262636363636363636363636363;
   localparam logic [127:0] ZERO_RA = 128'hb43e236fef92e98f5be25118cb11cf8e;

   aes_key_expander dut (
      .Clk(clk),
      .Rst(rst),
      .CipherKey(cipher),
      .Load(load),
      .SelKey(sel),
      .Key(key),
      .Busy(busy),
      .KeyRy(ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push_fips();
      sb.push_back('{4'd1,  FIPS_R1});
      sb.push_back('{4'd2,  FIPS_R2});
      sb.push_back('{4'd10, FIPS_RA});
      sb.push_back('{4'd0,  FIPS_K});
      sb.push_back('{4'd13, FIPS_K});
      sb.push_back('{4'd15, FIPS_K});
   endtask

   task automatic push_zero();
      sb.push_back('{4'd1,  ZERO_R1});
      sb.push_back('{4'd10, ZERO_RA});
      sb.push_back('{4'd0,  128'h0});
      sb.push_back('{4'd11, 128'h0});
   endtask

   // Ends 1 ns after the edge that samples Load.
   task automatic pulse_load(input logic [127:0] k);
      @(posedge clk);
      #1 cipher = k;
      load = 1'b1;
      @(posedge clk);
      #1 load = 1'b0;
   endtask

   // Counts edges until KeyRy, bounded at 20.
   task automatic wait_ready(output int cyc);
      cyc = 0;
      while (!ready && cyc < 20) begin
         @(posedge clk);
         #1 cyc++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      cipher = '0;
      load = 1'b0;
      sel = 4'd0;
      #12;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busy got %b want 0", busy);
      end
      n_checks++;
      if (ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ready got %b want 0", ready);
      end
      for (int s = 0; s < 16; s += 5) begin
         sel = 4'(s);
         #1;
         n_checks++;
         if (key !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_key sel=%0d got %h want 0", s, key);
         end
      end
      #2 rst = 1'b1;
   endtask

   task automatic test_fips();
      int   cyc;
      exp_t e;
      pulse_load(FIPS_K);
      push_fips();
      n_checks++;
      if (busy !== 1'b1 || ready !== 1'b0) begin
         n_fail++;
         $display("FAIL fips_start got busy=%b ready=%b want 1 0", busy, ready);
      end
      wait_ready(cyc);
      n_checks++;
      if (cyc !== 10) begin
         n_fail++;
         $display("FAIL fips_latency got %0d want 10", cyc);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL fips_busy_done got %b want 0", busy);
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         sel = e.sel;
         #1;
         n_checks++;
         if (key !== e.key) begin
            n_fail++;
            $display("FAIL fips_key sel=%0d got %h want %h", e.sel, key, e.key);
         end
      end
   endtask

   task automatic test_reload_from_done();
      int   cyc;
      exp_t e;
      pulse_load(128'h0);
      push_zero();
      n_checks++;
      if (ready !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL reload_edge got ready=%b busy=%b want 0 1", ready, busy);
      end
      wait_ready(cyc);
      n_checks++;
      if (cyc !== 10) begin
         n_fail++;
         $display("FAIL reload_latency got %0d want 10", cyc);
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         sel = e.sel;
         #1;
         n_checks++;
         if (key !== e.key) begin
            n_fail++;
            $display("FAIL reload_key sel=%0d got %h want %h", e.sel, key, e.key);
         end
      end
   endtask

   task automatic test_reset_mid();
      int   cyc;
      exp_t e;
      pulse_load(FIPS_K);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #20;
      n_checks++;
      if (busy !== 1'b0 || ready !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_flags got busy=%b ready=%b want 0 0", busy, ready);
      end
      for (int s = 0; s < 16; s++) begin
         sel = 4'(s);
         #1;
         n_checks++;
         if (key !== 128'h0) begin
            n_fail++;
            $display("FAIL midrst_key sel=%0d got %h want 0", s, key);
         end
      end
      #3 rst = 1'b1;
      pulse_load(FIPS_K);
      push_fips();
      wait_ready(cyc);
      n_checks++;
      if (cyc !== 10) begin
         n_fail++;
         $display("FAIL midrst_latency got %0d want 10", cyc);
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         sel = e.sel;
         #1;
         n_checks++;
         if (key !== e.key) begin
            n_fail++;
            $display("FAIL midrst_key2 sel=%0d got %h want %h", e.sel, key, e.key);
         end
      end
   endtask

   task automatic test_load_during_expand();
      int   cyc;
      exp_t e;
      pulse_load(FIPS_K);
      push_fips();
      repeat (4) @(posedge clk);
      #1 cipher = 128'h0;
      load = 1'b1;
      @(posedge clk);
      #1 load = 1'b0;
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL midload_busy got %b want 1", busy);
      end
      wait_ready(cyc);
      n_checks++;
      if (cyc !== 5) begin
         n_fail++;
         $display("FAIL midload_latency got %0d want 5", cyc);
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         sel = e.sel;
         #1;
         n_checks++;
         if (key !== e.key) begin
            n_fail++;
            $display("FAIL midload_key sel=%0d got %h want %h", e.sel, key, e.key);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fips();
      test_reload_from_done();
      test_reset_mid();
      test_load_during_expand();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule
